multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller.sv | 205 ++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multicycle RV32 subset control FSM: lw 5, sw/R/I/jal 4, beq 3, illegal 2 cycles including FETCH.
// Never stalls; advances every clock. rst returns to FETCH and masks every write strobe and pulse.
module multicycle_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] OP,
    input  logic [2:0] funct3,
    input  logic       funct75,
    input  logic       zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUcon,
    output logic [1:0] ImmSrc,
    output logic [3:0] state,
    output logic       instr_done,
    output logic       illegal_op
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECUTEI = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'd0,
        ALUOP_SUB   = 2'd1,
        ALUOP_FUNCT = 2'd2
    } aluop_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    state_t     state_q;
    state_t     state_d;
    aluop_t     aluop;
    logic       pc_update;
    logic       branch;
    logic       irwrite_raw;
    logic       memwrite_raw;
    logic       regwrite_raw;
    logic       done_raw;
    logic       illegal_raw;
    logic [2:0] alu_funct;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // OP[5] separates R-type (sub allowed) from I-type (addi has no subi form).
    always_comb begin
        alu_funct = 3'b000;
        case (funct3)
            3'b000:  alu_funct = (OP[5] && funct75) ? 3'b001 : 3'b000;
            3'b010:  alu_funct = 3'b101;
            3'b110:  alu_funct = 3'b011;
            3'b111:  alu_funct = 3'b010;
            default: alu_funct = 3'b000;
        endcase
    end

    always_comb begin
        state_d      = S_FETCH;
        aluop        = ALUOP_ADD;
        pc_update    = 1'b0;
        branch       = 1'b0;
        irwrite_raw  = 1'b0;
        memwrite_raw = 1'b0;
        regwrite_raw = 1'b0;
        done_raw     = 1'b0;
        illegal_raw  = 1'b0;
        AdrSrc       = 1'b0;
        ResultSrc    = 2'b00;
        ALUSrcA      = 2'b00;
        ALUSrcB      = 2'b00;
        case (state_q)
            S_FETCH: begin
                state_d     = S_DECODE;
                irwrite_raw = 1'b1;
                ALUSrcB     = 2'b10;
                ResultSrc   = 2'b10;
                pc_update   = 1'b1;
            end
            S_DECODE: begin
                // Computes the branch/jump target into ALUOut while the opcode is decoded.
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (OP)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTER;
                    OP_ITYPE:     state_d = S_EXECUTEI;
                    OP_JAL:       state_d = S_JAL;
                    OP_BEQ:       state_d = S_BEQ;
                    default: begin
                        state_d     = S_FETCH;
                        illegal_raw = 1'b1;
                        done_raw    = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                state_d = (OP == OP_LW) ? S_MEMREAD : S_MEMWRITE;
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: begin
                state_d = S_MEMWB;
                AdrSrc  = 1'b1;
            end
            S_MEMWB: begin
                state_d      = S_FETCH;
                ResultSrc    = 2'b01;
                regwrite_raw = 1'b1;
                done_raw     = 1'b1;
            end
            S_MEMWRITE: begin
                state_d      = S_FETCH;
                AdrSrc       = 1'b1;
                memwrite_raw = 1'b1;
                done_raw     = 1'b1;
            end
            S_EXECUTER: begin
                state_d = S_ALUWB;
                ALUSrcA = 2'b10;
                aluop   = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                state_d = S_ALUWB;
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                state_d      = S_FETCH;
                regwrite_raw = 1'b1;
                done_raw     = 1'b1;
            end
            S_JAL: begin
                state_d   = S_ALUWB;
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
            end
            S_BEQ: begin
                state_d  = S_FETCH;
                ALUSrcA  = 2'b10;
                aluop    = ALUOP_SUB;
                branch   = 1'b1;
                done_raw = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        ALUcon = 3'b000;
        case (aluop)
            ALUOP_SUB:   ALUcon = 3'b001;
            ALUOP_FUNCT: ALUcon = alu_funct;
            default:     ALUcon = 3'b000;
        endcase
    end

    always_comb begin
        ImmSrc = 2'b00;
        case (OP)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    // Strobes are masked combinationally so nothing commits while reset is held.
    assign PCWrite    = ~rst & (pc_update | (branch & zero));
    assign IRWrite    = ~rst & irwrite_raw;
    assign MemWrite   = ~rst & memwrite_raw;
    assign RegWrite   = ~rst & regwrite_raw;
    assign instr_done = ~rst & done_raw;
    assign illegal_op = ~rst & illegal_raw;
    assign state      = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized instruction stream against a per-instruction phase model; directed pins for key cases.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] OP = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct75 = 1'b0;
    logic       zero = 1'b0;
    logic       PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUcon;
    logic [3:0] state;
    logic       instr_done, illegal_op;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk(clk), .rst(rst), .OP(OP), .funct3(funct3), .funct75(funct75), .zero(zero),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUcon(ALUcon), .ImmSrc(ImmSrc), .state(state), .instr_done(instr_done),
        .illegal_op(illegal_op)
    );

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] IT = 7'b0010011, JL = 7'b1101111, BQ = 7'b1100011;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, adr, irw, memw, regw;
        logic [1:0] res, a, b;
        logic [2:0] alu;
        logic [1:0] imm;
        logic       done, ill;
    } exp_t;

    exp_t act, exp_cur, snap_rst;
    exp_t snap [0:10];
    logic chk_en = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;

    assign act = {state, PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc,
                  ALUSrcA, ALUSrcB, ALUcon, ImmSrc, instr_done, illegal_op};

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (chk_en) begin
            n_chk++;
            if (act === exp_cur) n_pass++;
            else $display("FAIL cycle_outputs cyc=%0d state act=%0d exp=%0d vec act=%h exp=%h",
                          cyc, act.st, exp_cur.st, act, exp_cur);
        end
    end

    task automatic pin(input string nm, input logic [3:0] a, input logic [3:0] e);
        n_chk++;
        if (a === e) n_pass++;
        else $display("FAIL %s act=%0h exp=%0h", nm, a, e);
    endtask

    function automatic int n_phases(input logic [6:0] op);
        case (op)
            LW:             return 5;
            SW, RT, IT, JL: return 4;
            BQ:             return 3;
            default:        return 2;
        endcase
    endfunction

    // Which state code the instruction occupies in its i-th cycle.
    function automatic int phase_at(input logic [6:0] op, input int i);
        if (i < 2) return i;
        case (op)
            LW:      return (i == 2) ? 2 : (i == 3) ? 3 : 4;
            SW:      return (i == 2) ? 2 : 5;
            RT:      return (i == 2) ? 6 : 7;
            IT:      return (i == 2) ? 8 : 7;
            JL:      return (i == 2) ? 9 : 7;
            BQ:      return 10;
            default: return 0;
        endcase
    endfunction

    function automatic exp_t model(input int ph, input logic [6:0] op, input logic [2:0] f3,
                                   input logic f75, input logic z, input logic r);
        exp_t e;
        logic legal, pcupd, br;
        logic [2:0] afn;
        e = '0;
        e.st = 4'(ph);
        e.imm = (op == SW) ? 2'b01 : (op == BQ) ? 2'b10 : (op == JL) ? 2'b11 : 2'b00;
        legal = (op == LW) || (op == SW) || (op == RT) || (op == IT) || (op == JL) || (op == BQ);
        case (f3)
            3'b000:  afn = (op[5] && f75) ? 3'b001 : 3'b000;
            3'b010:  afn = 3'b101;
            3'b110:  afn = 3'b011;
            3'b111:  afn = 3'b010;
            default: afn = 3'b000;
        endcase
        pcupd = 1'b0;
        br = 1'b0;
        case (ph)
            0:  begin e.irw = 1; e.b = 2'b10; e.res = 2'b10; pcupd = 1; end
            1:  begin e.a = 2'b01; e.b = 2'b01; e.ill = !legal; e.done = !legal; end
            2:  begin e.a = 2'b10; e.b = 2'b01; end
            3:  e.adr = 1;
            4:  begin e.res = 2'b01; e.regw = 1; e.done = 1; end
            5:  begin e.adr = 1; e.memw = 1; e.done = 1; end
            6:  begin e.a = 2'b10; e.alu = afn; end
            7:  begin e.regw = 1; e.done = 1; end
            8:  begin e.a = 2'b10; e.b = 2'b01; e.alu = afn; end
            9:  begin e.a = 2'b01; e.b = 2'b10; pcupd = 1; end
            10: begin e.a = 2'b10; e.alu = 3'b001; br = 1; e.done = 1; end
            default: ;
        endcase
        e.pcw = pcupd | (br & z);
        if (r) begin
            e.pcw = 0; e.irw = 0; e.memw = 0; e.regw = 0; e.done = 0; e.ill = 0;
        end
        return e;
    endfunction

    // Entry and exit: #1 after the rising edge that starts a FETCH cycle.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                             input logic zb, input int rst_at);
        int ph;
        OP = op; funct3 = f3; funct75 = f75;
        for (int i = 0; i < n_phases(op); i++) begin
            ph = phase_at(op, i);
            zero = (ph == 10) ? zb : 1'($urandom);
            if (i == rst_at) rst = 1'b1;
            exp_cur = model(ph, op, f3, f75, zero, rst);
            chk_en = 1'b1;
            @(negedge clk); #1;
            snap[ph] = act;
            @(posedge clk); #1;
            if (rst) begin
                exp_cur = model(0, op, f3, f75, zero, 1'b1);
                @(negedge clk); #1;
                snap_rst = act;
                @(posedge clk); #1;
                rst = 1'b0;
                break;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0] rf3 [5];
        logic       rf75 [5];
        logic [3:0] ralu [5];
        logic [6:0] ops [6];
        logic [6:0] op;
        int len, ra;
        rf3  = '{3'b000, 3'b000, 3'b111, 3'b110, 3'b010};
        rf75 = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        ralu = '{4'h1, 4'h0, 4'h2, 4'h3, 4'h5};
        ops  = '{LW, SW, RT, IT, JL, BQ};

        rst = 1'b1;
        @(posedge clk); #1;
        exp_cur = model(0, OP, funct3, funct75, zero, 1'b1);
        chk_en = 1'b1;
        @(negedge clk); #1;
        pin("reset_state", act.st, 4'd0);
        pin("reset_irwrite_masked", 4'(act.irw), 4'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_instr(LW, 3'b010, 1'b0, 1'b0, -1);
        pin("lw_memread_regwrite", 4'(snap[3].regw), 4'd0);
        pin("lw_memread_adrsrc", 4'(snap[3].adr), 4'd1);
        pin("lw_memwb_regwrite", 4'(snap[4].regw), 4'd1);
        pin("lw_memwb_adrsrc", 4'(snap[4].adr), 4'd0);
        pin("lw_memwb_done", 4'(snap[4].done), 4'd1);

        for (int k = 0; k < 5; k++) begin
            run_instr(RT, rf3[k], rf75[k], 1'b0, -1);
            pin("rtype_alucon", 4'(snap[6].alu), ralu[k]);
        end

        run_instr(BQ, 3'b000, 1'b0, 1'b1, -1);
        pin("beq_taken_pcwrite", 4'(snap[10].pcw), 4'd1);
        pin("beq_alucon", 4'(snap[10].alu), 4'd1);
        pin("beq_immsrc", 4'(snap[10].imm), 4'd2);
        run_instr(BQ, 3'b000, 1'b0, 1'b0, -1);
        pin("beq_nottaken_pcwrite", 4'(snap[10].pcw), 4'd0);

        run_instr(SW, 3'b010, 1'b0, 1'b0, -1);
        pin("sw_memwrite", 4'(snap[5].memw), 4'd1);
        pin("sw_adrsrc", 4'(snap[5].adr), 4'd1);
        pin("sw_immsrc", 4'(snap[5].imm), 4'd1);
        pin("sw_regwrite", 4'(snap[5].regw), 4'd0);

        run_instr(7'b1111111, 3'b000, 1'b0, 1'b0, -1);
        pin("illegal_flag", 4'(snap[1].ill), 4'd1);
        pin("illegal_done", 4'(snap[1].done), 4'd1);

        run_instr(LW, 3'b010, 1'b0, 1'b0, 3);
        pin("rst_memread_state", snap[3].st, 4'd3);
        pin("rst_memread_regwrite", 4'(snap[3].regw), 4'd0);
        pin("rst_next_state", snap_rst.st, 4'd0);
        pin("rst_next_regwrite", 4'(snap_rst.regw), 4'd0);
        run_instr(IT, 3'b000, 1'b1, 1'b0, -1);
        pin("addi_no_sub", 4'(snap[8].alu), 4'd0);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 6) == 6) begin
                op = 7'($urandom);
                if (n_phases(op) != 2) op = 7'b1111111;
            end else begin
                op = ops[$urandom_range(0, 5)];
            end
            len = n_phases(op);
            ra = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, len - 1)) : -1;
            run_instr(op, 3'($urandom), 1'($urandom), 1'($urandom), ra);
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
